aes_iter_cipher_ctrl: RTL and testbench
=======================================

Name: aes_iter_cipher_ctrl

Overview:
Iterative AES encryption engine sitting directly downstream of the round-key generator. It accepts one plaintext/key/mode transaction and holds the key and mode for the generator. Each cycle it drives the round index to the generator, consumes the returned 128-bit round key, and applies one AES round. It returns the ciphertext over a valid/ready handshake and supports AES-128, AES-192 and AES-256.

Parameters:
RSVD_MODE_ERR, 1, 1: a start with mode 2'b11 is rejected with an err pulse; 0: mode 2'b11 is executed as 2'b10.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
mode  in  2  00 AES-128, 01 AES-192, 10 AES-256, 11 reserved
key_in  in  256  cipher key; 128/192 keys in low bits, AES-256 first key half in [255:128]
pt_in  in  128  plaintext block
out_valid  out  1  ct_out valid
out_ready  in  1  downstream accepts ct_out
ct_out  out  128  ciphertext
err  out  1  one-cycle pulse, reserved mode rejected
busy  out  1  transaction in progress (state != IDLE)
rk_mode  out  2  latched mode, to generator mode
rk_key  out  256  latched key, to generator key_in
rk_round  out  4  round index, to generator round
round_key  in  128  generator output, combinational from rk_*

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - in_ready=1, out_valid=0, err=0, busy=0.
  - ct_out, rk_key, the internal state register and rk_round = 0.
  - rk_mode=00.
  - Reset mid-transaction abandons the work with no output.
- Nr: 10 for mode 00, 12 for mode 01, 14 for mode 10 (also 14 for mode 11 when RSVD_MODE_ERR=0).
- FSM states: IDLE, ADD0, ROUND, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready with a legal mode: latch pt_in into the state register, key_in into rk_key, and mode into rk_mode; set rk_round=0; go to ADD0.
  - Reserved mode with RSVD_MODE_ERR=1: nothing is latched, err=1 for the next cycle, stay in IDLE.
- ADD0: state <= state ^ round_key (rk_round=0); rk_round <= 1; go to ROUND.
- ROUND, rk_round < Nr: state <= MixColumns(ShiftRows(SubBytes(state))) ^ round_key; rk_round increments.
- ROUND, rk_round == Nr: final round without MixColumns; ct_out <= result; go to DONE.
- DONE: out_valid=1 and ct_out held stable until out_ready.
  - On out_valid&out_ready: out_valid <= 0, go to IDLE.
  - in_ready is 0 in DONE (no same-cycle turnaround); the next accept is possible one cycle after the handshake.
- Latency: with the accept in cycle 0, out_valid is high from cycle Nr+2. That is cycle 12, 14 and 16 for AES-128/192/256.
- in_ready is 1 only in IDLE. Inputs are ignored when not in IDLE.
- rk_key and rk_mode are stable for the whole transaction. rk_round is in the range 0..Nr and never wraps.
- round_key is used in the same cycle rk_round is driven; no generator pipeline stage.
- State byte order is FIPS-197: byte 0 = bits [127:120], column-major.
- Round datapath uses the team's combinational SubBytes/ShiftRows/MixColumns functions; one round per cycle.
- err is high in exactly one cycle per rejected request.

Test Plan:
- AES-128:
  - Stimulus: mode=00, key_in[127:0]=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, out_ready=1.
  - Response: ct_out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid first in cycle 12; rk_round sequence 0..10.
- AES-192:
  - Stimulus: mode=01, key_in[191:0]=000102...1617, same pt.
  - Response: ct_out=dda97ca4864cdfe06eaf70a0ec0d7191 in cycle 14.
- AES-256:
  - Stimulus: mode=10, key_in=000102...1e1f, same pt.
  - Response: ct_out=8ea2b7ca516745bfeafc49904b496089 in cycle 16; rk_round reaches 14.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid held high with a second request.
  - Response: ct_out stable, in_ready=0 throughout; the second request is accepted one cycle after the handshake and yields the correct second result.
- Reserved mode:
  - Stimulus: mode=11, in_valid=1.
  - Response with RSVD_MODE_ERR=1: err high exactly one cycle, busy stays 0, rk_key unchanged.
  - Response with RSVD_MODE_ERR=0: AES-256 result 8ea2b7ca... .
- Reset mid-op:
  - Stimulus: rst_n low during round 5 of AES-128.
  - Response: all outputs immediately at reset values, no out_valid; a fresh request afterwards gives 69c4e0d8... .

Source files
------------

// File: rtl/aes_iter_cipher_ctrl.sv
// Iterative AES encryption core: one round per clock, round keys supplied
// combinationally by an external generator driven from rk_mode/rk_key/rk_round.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// ADD0  | initial AddRoundKey with round key 0
// ROUND | rounds 1..Nr, the last one skips MixColumns
// DONE  | ciphertext presented until out_ready
module aes_iter_cipher_ctrl #(
  parameter bit RSVD_MODE_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  input  logic [127:0] pt_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         err,
  output logic         busy,
  output logic [1:0]   rk_mode,
  output logic [255:0] rk_key,
  output logic [3:0]   rk_round,
  input  logic [127:0] round_key
);

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ADD0, ROUND, DONE} st_t;

  st_t          st;
  logic [127:0] state_q;
  logic [3:0]   nr;
  logic         last;
  logic [127:0] round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // byte x sits at bit offset 8*(255-x), which is {~x, 3'b000}
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows and (unless skip_mix) MixColumns on a column-major state
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic skip_mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[4*c+rw] = b[4*((c+rw)%4)+rw];
    if (!skip_mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c+1];
        a2 = t[4*c+2];
        a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  // Round count from the latched mode, and the datapath for the current round
  always_comb begin
    nr        = (rk_mode == 2'b00) ? 4'd10 : (rk_mode == 2'b01) ? 4'd12 : 4'd14;
    last      = (rk_round == nr);
    round_out = aes_round(state_q, last) ^ round_key;
  end

  // Control FSM with registered handshake, status and generator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ct_out    <= '0;
      rk_key    <= '0;
      rk_mode   <= 2'b00;
      rk_round  <= 4'd0;
      state_q   <= '0;
    end else begin
      err <= 1'b0;
      case (st)
        IDLE: begin
          if (in_valid) begin
            if (mode == 2'b11 && RSVD_MODE_ERR) begin
              err <= 1'b1;
            end else begin
              state_q  <= pt_in;
              rk_key   <= key_in;
              // reserved mode runs as AES-256 so the generator never sees 2'b11
              rk_mode  <= (mode == 2'b11) ? 2'b10 : mode;
              rk_round <= 4'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              st       <= ADD0;
            end
          end
        end
        ADD0: begin
          state_q  <= state_q ^ round_key;
          rk_round <= 4'd1;
          st       <= ROUND;
        end
        ROUND: begin
          if (last) begin
            ct_out    <= round_out;
            out_valid <= 1'b1;
            st        <= DONE;
          end else begin
            state_q  <= round_out;
            rk_round <= rk_round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_cipher_ctrl.sv
// Bench for aes_iter_cipher_ctrl: unit 0 rejects the reserved mode, unit 1
// executes it as AES-256. The bench acts as the round-key generator and keeps
// a transaction-level reference model checked every cycle.
module tb_aes_iter_cipher_ctrl;

  localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [1:0][1:0]   mode, rk_mode;
  logic [1:0][255:0] key_in, rk_key;
  logic [1:0][127:0] pt_in, ct_out, round_key;
  logic [1:0][3:0]   rk_round;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_cipher_ctrl #(.RSVD_MODE_ERR(1'b1)) dut_err (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mode(mode[0]), .key_in(key_in[0]), .pt_in(pt_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ct_out(ct_out[0]), .err(err[0]), .busy(busy[0]),
    .rk_mode(rk_mode[0]), .rk_key(rk_key[0]), .rk_round(rk_round[0]),
    .round_key(round_key[0]));

  aes_iter_cipher_ctrl #(.RSVD_MODE_ERR(1'b0)) dut_exec (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mode(mode[1]), .key_in(key_in[1]), .pt_in(pt_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ct_out(ct_out[1]), .err(err[1]), .busy(busy[1]),
    .rk_mode(rk_mode[1]), .rk_key(rk_key[1]), .rk_round(rk_round[1]),
    .round_key(round_key[1]));

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic int nr_of(input logic [1:0] md);
    return (md == 2'b00) ? 10 : (md == 2'b01) ? 12 : 14;
  endfunction

  function automatic logic [127:0] expand_rk(input logic [1:0] md, input logic [255:0] k,
                                             input logic [3:0] rd);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = (md == 2'b00) ? 4 : (md == 2'b01) ? 6 : 8;
    for (int i = 0; i < nk; i++) w[i] = k[32*nk-1-32*i -: 32];
    for (int i = nk; i < 64; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [1:0] md, input logic [255:0] k,
                                           input logic [127:0] p);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk;
    logic [127:0] o = '0;
    int nr = nr_of(md);
    rk = expand_rk(md, k, 4'd0);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb(s[r][(c+r)%4]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rd < nr) ? gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                                t[(r+2)%4][c] ^ t[(r+3)%4][c]
                              : t[r][c];
      rk = expand_rk(md, k, 4'(rd));
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // Bench plays the round-key generator: combinational from rk_*
  always_comb begin
    round_key = '0;
    for (int u = 0; u < 2; u++) round_key[u] = expand_rk(rk_mode[u], rk_key[u], rk_round[u]);
  end

  task automatic chk(input string nm, input int u, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (unit %0d): got %h, expected %h", nm, u, act, exp);
  endtask

  // ---------------- transaction-level model, checked every cycle ----------------
  bit           m_act   [2];
  int           m_age   [2];
  int           m_nr    [2];
  int           m_round [2];
  bit           m_err   [2];
  logic [127:0] m_ct    [2];
  logic [127:0] m_ct_nx [2];
  logic [255:0] m_key   [2];
  logic [1:0]   m_mode  [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit was_act;
      bit exp_ov;
      int exp_round;
      if (!rst_n) begin
        m_act[u] = 0; m_err[u] = 0; m_round[u] = 0;
        m_ct[u] = '0; m_key[u] = '0; m_mode[u] = 2'b00;
        chk("rst in_ready", u, 256'(in_ready[u]), 256'(1));
        chk("rst out_valid", u, 256'(out_valid[u]), 256'(0));
        chk("rst busy", u, 256'(busy[u]), 256'(0));
        chk("rst err", u, 256'(err[u]), 256'(0));
        chk("rst ct_out", u, 256'(ct_out[u]), 256'(0));
        chk("rst rk_key", u, rk_key[u], 256'(0));
        chk("rst rk_mode", u, 256'(rk_mode[u]), 256'(0));
        chk("rst rk_round", u, 256'(rk_round[u]), 256'(0));
      end else begin
        was_act = m_act[u];
        if (was_act) begin
          if (m_age[u] == m_nr[u] + 2) m_ct[u] = m_ct_nx[u];
          exp_ov    = (m_age[u] >= m_nr[u] + 2);
          exp_round = exp_ov ? m_nr[u] : m_age[u] - 1;
        end else begin
          exp_ov    = 0;
          exp_round = m_round[u];
        end
        chk("in_ready", u, 256'(in_ready[u]), 256'(!was_act));
        chk("out_valid", u, 256'(out_valid[u]), 256'(exp_ov));
        chk("busy", u, 256'(busy[u]), 256'(was_act));
        chk("err", u, 256'(err[u]), 256'(m_err[u]));
        chk("ct_out", u, 256'(ct_out[u]), 256'(m_ct[u]));
        chk("rk_key", u, rk_key[u], m_key[u]);
        chk("rk_mode", u, 256'(rk_mode[u]), 256'(m_mode[u]));
        chk("rk_round", u, 256'(rk_round[u]), 256'(exp_round));
        m_err[u] = 0;
        if (was_act) begin
          if (exp_ov && out_ready[u]) begin
            m_act[u]   = 0;
            m_round[u] = m_nr[u];
          end else begin
            m_age[u]++;
          end
        end else if (in_valid[u]) begin
          if (mode[u] == 2'b11 && u == 0) begin
            m_err[u] = 1;
          end else begin
            m_act[u]   = 1;
            m_age[u]   = 1;
            m_key[u]   = key_in[u];
            m_mode[u]  = (mode[u] == 2'b11) ? 2'b10 : mode[u];
            m_nr[u]    = nr_of(m_mode[u]);
            m_ct_nx[u] = aes_ref(m_mode[u], key_in[u], pt_in[u]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present a request and hold it until accepted; t0 is the accept cycle number
  task automatic send(input int u, input logic [1:0] md, input logic [255:0] k,
                      input logic [127:0] p, output int t0);
    bit acc = 0;
    t0 = -1;
    in_valid[u] = 1'b1; mode[u] = md; key_in[u] = k; pt_in[u] = p;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      if (in_ready[u]) begin
        acc = 1;
        t0 = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid[u] = 1'b0;
    if (!acc) chk("accept timeout", u, 256'(0), 256'(1));
  endtask

  task automatic wait_out(input int u, input logic [127:0] exp_ct, input int exp_lat,
                          input int t0, input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid[u]) seen = 1;
    end
    if (!seen) begin
      chk({nm, " timeout"}, u, 256'(0), 256'(1));
    end else begin
      chk({nm, " ct"}, u, 256'(ct_out[u]), 256'(exp_ct));
      chk({nm, " latency"}, u, 256'(cyc - t0), 256'(exp_lat));
      chk({nm, " final rk_round"}, u, 256'(rk_round[u]), 256'(exp_lat - 2));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, hs;
    bit seen;
    rst_n = 1'b0;
    in_valid = '0; out_ready = 2'b11; mode = '0; key_in = '0; pt_in = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // pin the reference model to published values
    chk("model sbox 53", 0, 256'(sb(8'h53)), 256'(8'hed));
    chk("model rk10 aes128", 0, 256'(expand_rk(2'b00, K128, 4'd10)),
        256'(128'h13111d7fe3944a17f307a78b4d2b30c5));
    chk("model aes128", 0, 256'(aes_ref(2'b00, K128, PT)), 256'(CT128));
    chk("model aes256", 0, 256'(aes_ref(2'b10, K256, PT)), 256'(CT256));

    send(0, 2'b00, K128, PT, t0); wait_out(0, CT128, 12, t0, "aes128");
    send(0, 2'b01, K192, PT, t0); wait_out(0, CT192, 14, t0, "aes192");
    send(0, 2'b10, K256, PT, t0); wait_out(0, CT256, 16, t0, "aes256");

    // backpressure with a second request waiting
    send(0, 2'b00, K128, PT, t0);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; mode[0] = 2'b01; key_in[0] = K192; pt_in[0] = PT;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    chk("bp out_valid seen", 0, 256'(seen), 256'(1));
    chk("bp latency", 0, 256'(cyc - t0), 256'(12));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp ct stable", 0, 256'(ct_out[0]), 256'(CT128));
      chk("bp in_ready low", 0, 256'(in_ready[0]), 256'(0));
      chk("bp out_valid held", 0, 256'(out_valid[0]), 256'(1));
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    hs = cyc;
    send(0, 2'b01, K192, PT, t1);
    chk("bp turnaround", 0, 256'(t1), 256'(hs + 1));
    wait_out(0, CT192, 14, t1, "bp second");

    // reserved mode rejected on unit 0
    send(0, 2'b11, K256, PT, t0);
    chk("rsvd err pulse", 0, 256'(err[0]), 256'(1));
    chk("rsvd busy", 0, 256'(busy[0]), 256'(0));
    chk("rsvd rk_key kept", 0, rk_key[0], K192);
    @(posedge clk); #1;
    chk("rsvd err single", 0, 256'(err[0]), 256'(0));

    // reserved mode executed as AES-256 on unit 1
    send(1, 2'b11, K256, PT, t0); wait_out(1, CT256, 16, t0, "rsvd exec");

    // reset during round 5 of AES-128
    send(0, 2'b00, K128, PT, t0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rk_round[0] == 4'd5) seen = 1;
    end
    chk("mid reached round 5", 0, 256'(seen), 256'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst busy", 0, 256'(busy[0]), 256'(0));
    chk("mid rst out_valid", 0, 256'(out_valid[0]), 256'(0));
    chk("mid rst in_ready", 0, 256'(in_ready[0]), 256'(1));
    chk("mid rst rk_round", 0, 256'(rk_round[0]), 256'(0));
    chk("mid rst rk_key", 0, rk_key[0], 256'(0));
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 2'b00, K128, PT, t0); wait_out(0, CT128, 12, t0, "after reset");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
